// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals for alu_arbiter.
// slave is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_r15;
    logic             alu_of;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_out;
    logic [WIDTH-1:0] rsp_r15;
    logic             rsp_of;
    logic             rsp_err;
    logic [15:0]      ops_done;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_out, alu_r15, alu_of, rsp_ready,
        output req0_ready, req1_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_out, rsp_r15, rsp_of, rsp_err, ops_done
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_out, alu_r15, alu_of, rsp_ready,
        input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_out, rsp_r15, rsp_of, rsp_err, ops_done
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle ALU: alternating grant on ties,
// operands held for EXEC_CYCLES, result captured and offered on a valid/ready response.
module alu_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input logic           clk,
    input logic           rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [2:0] OpIllegal = 3'b111;
    localparam logic [3:0] CntInit   = 4'(EXEC_CYCLES - 1);

    state_e           state_q;
    logic             last_q;
    logic [3:0]       cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic [WIDTH-1:0] rsp_r15_q;
    logic             rsp_of_q;
    logic             rsp_err_q;
    logic [15:0]      ops_done_q;

    logic             grant_any;
    logic             grant_id;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Ready is combinational so a requester that drops valid is never granted.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_q;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
        sel_op = grant_id ? bus.req1_op : bus.req0_op;
        sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
        sel_b  = grant_id ? bus.req1_b  : bus.req0_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_r15_q   <= '0;
            rsp_of_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        last_q <= grant_id;
                        id_q   <= grant_id;
                        // Illegal ops never reach the ALU, so its inputs keep the last legal op.
                        if (sel_op == OpIllegal) begin
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= grant_id;
                            rsp_out_q   <= '0;
                            rsp_r15_q   <= '0;
                            rsp_of_q    <= 1'b0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            op_q    <= sel_op;
                            a_q     <= sel_a;
                            b_q     <= sel_b;
                            cnt_q   <= CntInit;
                            state_q <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_out_q   <= bus.alu_out;
                        rsp_r15_q   <= bus.alu_r15;
                        rsp_of_q    <= bus.alu_of;
                        rsp_err_q   <= 1'b0;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ops_done_q  <= ops_done_q + 16'd1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any && grant_id;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_out    = rsp_out_q;
    assign bus.rsp_r15    = rsp_r15_q;
    assign bus.rsp_of     = rsp_of_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.ops_done   = ops_done_q;
endmodule
